// File: rtl/key_scan10_debounce.sv
// Ten-key front end: synchronises raw active-low key lines, debounces them on a
// slow sample tick and presents a zero-or-one-hot key vector with a press strobe.
module key_scan10_debounce #(
    parameter int TICK_DIV   = 50000,
    parameter int DB_SAMPLES = 20
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [9:0] i_key_n,
    output logic [9:0] o_data,
    output logic       o_valid
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CNT_W  = $clog2(DB_SAMPLES + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DB_SAMPLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        HELD,
        RELEASE
    } state_t;

    logic [9:0]        r_sync1;
    logic [9:0]        r_sync2;
    logic [TICK_W-1:0] r_tick_cnt;
    logic [CNT_W-1:0]  r_cnt;
    logic [9:0]        r_cand;
    logic [9:0]        r_data;
    logic              r_valid;
    state_t            r_state;

    logic [9:0] w_p;
    logic       w_tick;
    logic       w_p_zero;
    logic       w_p_onehot;
    logic       w_p_cand;
    logic       w_cnt_last;

    // Sync flops come out of reset as "all keys released" so no phantom press appears.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples the pre-edge value of its neighbours.
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TICK_W'(1);
        end
    end

    assign w_p        = ~r_sync2;
    assign w_tick     = (r_tick_cnt == TICK_LAST);
    assign w_p_zero   = (w_p == '0);
    assign w_p_onehot = !w_p_zero && ((w_p & (w_p - 10'd1)) == '0);
    assign w_p_cand   = (w_p == r_cand);
    assign w_cnt_last = (r_cnt == CNT_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_cand  <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_tick) begin
                case (r_state)
                    IDLE: begin
                        if (w_p_onehot) begin
                            r_cand  <= w_p;
                            r_cnt   <= CNT_ONE;
                            r_state <= DEBOUNCE;
                        end
                    end
                    DEBOUNCE: begin
                        if (w_p_cand && w_cnt_last) begin
                            r_data  <= r_cand;
                            r_valid <= 1'b1;
                            r_cnt   <= '0;
                            r_state <= HELD;
                        end else if (w_p_cand) begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end else begin
                            r_cnt   <= '0;
                            r_state <= IDLE;
                        end
                    end
                    HELD: begin
                        if (!w_p_cand) begin
                            r_cnt   <= w_p_zero ? CNT_ONE : '0;
                            r_state <= RELEASE;
                        end
                    end
                    RELEASE: begin
                        // Only an unbroken run of all-released samples lets go of the key.
                        if (w_p_zero && w_cnt_last) begin
                            r_data  <= '0;
                            r_cnt   <= '0;
                            r_state <= IDLE;
                        end else if (w_p_zero) begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end else if (w_p_cand) begin
                            r_cnt   <= '0;
                            r_state <= HELD;
                        end else begin
                            r_cnt <= '0;
                        end
                    end
                    default: begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule
